// File: rtl/seq_bla_sub.sv
// seq_bla_sub: nibble-serial subtractor, one 4-bit borrow-lookahead slice per cycle.
// Define SEQ_BLA_SUB_OVF_EN to enable the signed overflow flag (ovf tied low otherwise).
module seq_bla_sub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_brw;
   logic             r_bout;
   logic [CW+1:0]    w_idx;
   logic [3:0]       w_an;
   logic [3:0]       w_bn;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic [3:0]       w_d;
   logic [4:0]       w_c;
   logic             w_accept;
   logic             w_step;
   logic             w_last;

   assign w_accept = (r_state == IDLE) & start;
   assign w_step   = (r_state == RUN);
   assign w_last   = w_step & (r_cnt == LAST);
   assign w_idx    = {r_cnt, 2'b00};

   assign w_an = r_a[w_idx +: 4];
   assign w_bn = r_b[w_idx +: 4];
   assign w_g  = ~w_an & w_bn;
   assign w_p  = ~(w_an ^ w_bn);

   // Flat two-level borrow lookahead across the current nibble
   always_comb begin
      w_c    = '0;
      w_c[0] = r_brw;
      w_c[1] = w_g[0]
             | (w_p[0] & r_brw);
      w_c[2] = w_g[1]
             | (w_p[1] & w_g[0])
             | (w_p[1] & w_p[0] & r_brw);
      w_c[3] = w_g[2]
             | (w_p[2] & w_g[1])
             | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & r_brw);
      w_c[4] = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_brw);
   end

   assign w_d = w_an ^ w_bn ^ w_c[3:0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; DONE always lasts a single cycle
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture, nibble write-back and borrow chaining
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_diff <= '0;
         r_cnt  <= '0;
         r_brw  <= 1'b0;
         r_bout <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_brw <= bin;
         r_cnt <= '0;
      end else if (w_step) begin
         r_diff[w_idx +: 4] <= w_d;
         r_brw              <= w_c[4];
         if (w_last) r_bout <= w_c[4];
         else        r_cnt  <= r_cnt + 1'b1;
      end
   end

`ifdef SEQ_BLA_SUB_OVF_EN
   logic r_ovf;

   // Signed overflow from captured sign bits and the final result sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ovf <= 1'b0;
      else if (w_last)
         r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1])
                & (r_a[WIDTH-1] ^ w_d[3]);
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_seq_bla_sub.sv
// tb_seq_bla_sub: directed and randomized checks of seq_bla_sub (WIDTH=16)
// against an integer-arithmetic reference model.
module tb_seq_bla_sub;
   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int n_chk;
   int n_err;

   seq_bla_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] ia,
                                 input logic [W-1:0] ib,
                                 input logic ibin,
                                 output logic [W-1:0] d,
                                 output logic bo,
                                 output logic ov);
      int u;
      int s;
      int sa;
      int sb;
      u  = int'(ia) - int'(ib) - int'(ibin);
      d  = u[W-1:0];
      bo = (u < 0);
      sa = int'($signed(ia));
      sb = int'($signed(ib));
      s  = sa - sb - int'(ibin);
`ifdef SEQ_BLA_SUB_OVF_EN
      ov = (s > 32767) || (s < -32768);
`else
      ov = 1'b0;
      if (s == 0) ov = 1'b0;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Entered in IDLE, just after a clock edge; leaves in IDLE likewise.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input bit full);
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int           cyc;
      int           nbusy;
      model(ia, ib, ibin, ed, eb, eo);
      start = 1'b1;
      a     = ia;
      b     = ib;
      bin   = ibin;
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      cyc   = 1;
      nbusy = 0;
      while (!done && cyc < 20) begin
         if (busy) nbusy++;
         tick();
         cyc++;
      end
      chk("diff", diff, ed);
      chk("bout", bout, eb);
      chk("ovf", ovf, eo);
      if (full) begin
         chk("latency", cyc, 5);
         chk("busy_cycles", nbusy, 4);
         chk("busy_in_done", busy, 0);
      end
      tick();
      if (full) begin
         chk("done_pulse", done, 0);
         chk("hold_diff", diff, ed);
         chk("hold_bout", bout, eb);
      end
   endtask

   initial begin
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int           cyc;
      int           ndone;
      n_chk = 0;
      n_err = 0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      rst   = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      do_op(16'h0005, 16'h0003, 1'b0, 1'b1);
      do_op(16'h1000, 16'h0001, 1'b0, 1'b1);
      do_op(16'h0000, 16'h0000, 1'b1, 1'b1);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      do_op(16'h8000, 16'h0000, 1'b1, 1'b1);
      do_op(16'h0000, 16'hFFFF, 1'b0, 1'b1);

      // start pulsed during RUN is ignored
      model(16'h1234, 16'h0235, 1'b1, ed, eb, eo);
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h0235;
      bin   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'h0001;
      bin   = 1'b0;
      tick();
      start = 1'b0;
      cyc   = 3;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("ign_latency", cyc, 5);
      chk("ign_diff", diff, ed);
      chk("ign_bout", bout, eb);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("ign_noqueue", ndone, 0);

      // start held high: back-to-back operations every 6 cycles
      model(16'hA5A5, 16'h5A5B, 1'b0, ed, eb, eo);
      start = 1'b1;
      a     = 16'hA5A5;
      b     = 16'h5A5B;
      bin   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (done) begin
            ndone++;
            chk("b2b_diff", diff, ed);
            chk("b2b_bout", bout, eb);
         end
      end
      chk("b2b_count", ndone, 4);
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // asynchronous reset in the middle of RUN
      start = 1'b1;
      a     = 16'h4321;
      b     = 16'h1234;
      bin   = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_diff", diff, 0);
      chk("mid_rst_bout", bout, 0);
      chk("mid_rst_ovf", ovf, 0);
      tick();
      #3 rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("mid_rst_nodone", ndone, 0);
      do_op(16'h4321, 16'h1234, 1'b1, 1'b1);

      for (int i = 0; i < 10000; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), (i % 64) == 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
